// File: rtl/traffic_lights_xn_pkg.sv
// traffic_lights_xn_pkg: shared types for the N-approach intersection controller.
// This package holds the command encoding, the controller state encoding and the millisecond time type.
package traffic_lights_xn_pkg;

  // A time value in milliseconds.
  typedef logic [15:0] ms_t;

  // Command bus encoding. Codes 6 and 7 are reserved and are ignored.
  typedef enum logic [2:0] {
    CMD_ON        = 3'd0,
    CMD_OFF       = 3'd1,
    CMD_UNMANAGED = 3'd2,
    CMD_SET_G     = 3'd3,
    CMD_SET_CLR   = 3'd4,
    CMD_SET_Y     = 3'd5
  } cmd_type_t;

  // Controller states. CLR through Y form the running round-robin sequence.
  typedef enum logic [2:0] {
    ST_OFF,
    ST_UNMANAGED,
    ST_CLR,
    ST_RY,
    ST_G,
    ST_GBLINK,
    ST_Y
  } state_t;

endpackage

// File: rtl/traffic_lights_xn_ms_timer.sv
// tl_ms_timer: a millisecond interval timer.
// A prescaler divides clk_i down to 1 ms ticks, and a 16-bit down-counter counts those ticks.
// load_i restarts both counters with ms_i. load_i has priority over counting.
// done_o is high during the last clock cycle of the interval. An interval of T ms therefore
// spans exactly T*CLK_PER_MS cycles, counted from the load edge.
// If load_i is asserted in the same cycle as done_o, the timer free-runs with the reloaded value.
module tl_ms_timer
  import traffic_lights_xn_pkg::*;
#(
  parameter int CLK_PER_MS = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  ms_t  ms_i,
  output logic done_o
);

  localparam int            PW     = $clog2(CLK_PER_MS + 1);
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_PER_MS - 1);

  logic [PW-1:0] pre_q;
  ms_t           cnt_q;
  logic          run_q;

  assign done_o = run_q && (pre_q == PRE_TC) && (cnt_q == ms_t'(1));

  // Prescaler and ms down-counter; the timer stops itself after the final tick unless reloaded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load_i) begin
      pre_q <= '0;
      cnt_q <= ms_i;
      run_q <= (ms_i != '0);
    end else if (run_q) begin
      if (pre_q == PRE_TC) begin
        pre_q <= '0;
        cnt_q <= cnt_q - ms_t'(1);
        if (cnt_q == ms_t'(1)) begin
          run_q <= 1'b0;
        end
      end else begin
        pre_q <= pre_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/traffic_lights_xn.sv
// traffic_lights_xn: round-robin N-approach intersection controller.
//
// Exactly one approach at a time runs its RY / G / GBLINK / Y phases. All other approaches
// show red, and an all-red clearance (CLR) separates consecutive approaches.
// Lamp outputs and active_ch_o are registered from the state register. A change of state
// made at edge k is therefore visible on the lamps from edge k+1.
//
// Optional build macro DEMAND_SKIP_EN: requests on req_i are latched per channel. At the end
// of a clearance, the next channel served is the first pending one after the active channel.
// While no request is pending, the controller holds all-red.
module traffic_lights_xn
  import traffic_lights_xn_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CLK_PER_MS  = 2,
  parameter int DEF_G_MS    = 10,
  parameter int DEF_Y_MS    = 3,
  parameter int DEF_CLR_MS  = 2,
  parameter int STATE_RY_MS = 3,
  parameter int BLINK_G_MS  = 1,
  parameter int G_BLINK_T   = 4,
  parameter int BLINK_Y_MS  = 8
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    cmd_valid_i,
  input  logic [2:0]              cmd_type_i,
  input  logic [15:0]             cmd_data_i,
  input  logic [$clog2(N_CH)-1:0] cmd_ch_i,
  input  logic [N_CH-1:0]         req_i,
  output logic [N_CH-1:0]         red_o,
  output logic [N_CH-1:0]         yellow_o,
  output logic [N_CH-1:0]         green_o,
  output logic [$clog2(N_CH)-1:0] active_ch_o
);

  localparam int  CW       = $clog2(N_CH);
  localparam ms_t RY_MS    = ms_t'(STATE_RY_MS);
  localparam ms_t GB_MS    = ms_t'(2 * G_BLINK_T * BLINK_G_MS);
  localparam ms_t BLG_MS   = ms_t'(BLINK_G_MS);
  localparam ms_t BLY_MS   = ms_t'(BLINK_Y_MS);
  localparam ms_t DEF_G    = ms_t'(DEF_G_MS);
  localparam ms_t DEF_Y    = ms_t'(DEF_Y_MS);
  localparam ms_t DEF_CLR  = ms_t'(DEF_CLR_MS);

  // Reset is asserted asynchronously and released synchronously. The whole controller
  // therefore leaves reset on one clock edge.
  logic [1:0] rst_sync_q;
  logic       rst;

  state_t          state_q, state_d;
  logic [CW-1:0]   act_q, act_d;
  logic [N_CH-1:0] act_oh;
  ms_t             g_q [N_CH];
  ms_t             y_q, clr_q;
  logic            enter;
  logic            mode_cmd;
  ms_t             ph_ms;
  logic            ph_done, gb_done, yb_done;
  logic            gb_load, yb_load;
  logic            gb_on_q, yb_on_q;
  logic [CW:0]     ch_ext;
  logic            ch_ok;

  logic [N_CH-1:0] red_q, yel_q, grn_q;
  logic [CW-1:0]   act_out_q;

`ifdef DEMAND_SKIP_EN
  logic [N_CH-1:0] pend_q;
  logic            wait_q, wait_d;
  logic [CW:0]     pick_w;

  // Returns {found, channel}: the first channel after act, in round-robin order, with a
  // pending request. The active channel itself is considered last.
  function automatic logic [CW:0] pick_next(input logic [CW-1:0] act,
                                            input logic [N_CH-1:0] pend);
    logic          found;
    logic [CW-1:0] res;
    int            idx;
    found = 1'b0;
    res   = act;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(act) + k) % N_CH;
      if (!found && pend[idx[CW-1:0]]) begin
        found = 1'b1;
        res   = idx[CW-1:0];
      end
    end
    return {found, res};
  endfunction

  assign pick_w = pick_next(act_q, pend_q);
`else
  logic unused_req;
  assign unused_req = ^req_i;
`endif

  // Round-robin successor of a channel, wrapping from N_CH-1 back to 0.
  function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] c);
    if (c == CW'(N_CH - 1)) begin
      return '0;
    end
    return c + CW'(1);
  endfunction

  assign rst    = rst_sync_q[1];
  assign act_oh = N_CH'(1) << act_q;
  assign ch_ext = {1'b0, cmd_ch_i};
  assign ch_ok  = (ch_ext < (CW + 1)'(N_CH));

  // Reset synchronizer: asserts immediately with arst_i and releases two edges later.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  // Next-state logic. Mode commands (on/off/unmanaged) take precedence over phase expiry.
  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    enter    = 1'b0;
    mode_cmd = 1'b0;
`ifdef DEMAND_SKIP_EN
    wait_d   = wait_q;
`endif
    if (cmd_valid_i) begin
      case (cmd_type_i)
        CMD_ON: begin
          if (state_q == ST_OFF || state_q == ST_UNMANAGED) begin
            state_d  = ST_CLR;
            act_d    = '0;
            enter    = 1'b1;
            mode_cmd = 1'b1;
          end
        end
        CMD_OFF: begin
          state_d  = ST_OFF;
          mode_cmd = 1'b1;
        end
        CMD_UNMANAGED: begin
          state_d  = ST_UNMANAGED;
          enter    = 1'b1;
          mode_cmd = 1'b1;
        end
        default: ;
      endcase
    end
    if (!mode_cmd) begin
      case (state_q)
        ST_CLR: begin
`ifdef DEMAND_SKIP_EN
          if (ph_done || wait_q) begin
            if (pick_w[CW]) begin
              act_d   = pick_w[CW-1:0];
              state_d = ST_RY;
              enter   = 1'b1;
            end else begin
              wait_d  = 1'b1;
            end
          end
`else
          if (ph_done) begin
            state_d = ST_RY;
            enter   = 1'b1;
          end
`endif
        end
        ST_RY: begin
          if (ph_done) begin
            state_d = ST_G;
            enter   = 1'b1;
          end
        end
        ST_G: begin
          if (ph_done) begin
            state_d = ST_GBLINK;
            enter   = 1'b1;
          end
        end
        ST_GBLINK: begin
          if (ph_done) begin
            state_d = ST_Y;
            enter   = 1'b1;
          end
        end
        ST_Y: begin
          if (ph_done) begin
            state_d = ST_CLR;
`ifndef DEMAND_SKIP_EN
            act_d   = next_ch(act_q);
`endif
            enter   = 1'b1;
          end
        end
        default: ;
      endcase
    end
`ifdef DEMAND_SKIP_EN
    if (enter) begin
      wait_d = 1'b0;
    end
`endif
  end

  // Duration loaded into the phase timer on entry to a phase. Registers are read before any
  // same-cycle write lands, so a new value applies only from the following load.
  always_comb begin
    ph_ms = '0;
    case (state_d)
      ST_CLR:    ph_ms = clr_q;
      ST_RY:     ph_ms = RY_MS;
      ST_G:      ph_ms = g_q[act_d];
      ST_GBLINK: ph_ms = GB_MS;
      ST_Y:      ph_ms = y_q;
      default:   ph_ms = '0;
    endcase
  end

  assign gb_load = (enter && state_d == ST_GBLINK) || (state_q == ST_GBLINK && gb_done);
  assign yb_load = (enter && state_d == ST_UNMANAGED) || (state_q == ST_UNMANAGED && yb_done);

  tl_ms_timer #(.CLK_PER_MS(CLK_PER_MS)) u_phase_tmr (
    .clk_i  (clk_i),
    .rst_i  (rst),
    .load_i (enter),
    .ms_i   (ph_ms),
    .done_o (ph_done)
  );

  tl_ms_timer #(.CLK_PER_MS(CLK_PER_MS)) u_gblink_tmr (
    .clk_i  (clk_i),
    .rst_i  (rst),
    .load_i (gb_load),
    .ms_i   (BLG_MS),
    .done_o (gb_done)
  );

  tl_ms_timer #(.CLK_PER_MS(CLK_PER_MS)) u_yblink_tmr (
    .clk_i  (clk_i),
    .rst_i  (rst),
    .load_i (yb_load),
    .ms_i   (BLY_MS),
    .done_o (yb_done)
  );

  // Controller state, active channel, timing registers and blink phases.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      act_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        g_q[i] <= DEF_G;
      end
      y_q     <= DEF_Y;
      clr_q   <= DEF_CLR;
      gb_on_q <= 1'b0;
      yb_on_q <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      if (cmd_valid_i && cmd_data_i != '0) begin
        case (cmd_type_i)
          CMD_SET_G:   if (ch_ok) g_q[cmd_ch_i] <= cmd_data_i;
          CMD_SET_CLR: clr_q <= cmd_data_i;
          CMD_SET_Y:   y_q   <= cmd_data_i;
          default: ;
        endcase
      end
      if (enter && state_d == ST_GBLINK) begin
        gb_on_q <= 1'b1;
      end else if (state_q == ST_GBLINK && gb_done) begin
        gb_on_q <= ~gb_on_q;
      end
      if (enter && state_d == ST_UNMANAGED) begin
        yb_on_q <= 1'b1;
      end else if (state_q == ST_UNMANAGED && yb_done) begin
        yb_on_q <= ~yb_on_q;
      end
    end
  end

`ifdef DEMAND_SKIP_EN
  // Sticky per-channel demand, cleared as the owning channel enters green; plus the CLR hold flag.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      wait_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      pend_q <= (pend_q & ~((enter && state_d == ST_G) ? act_oh : '0)) | req_i;
    end
  end
`endif

  // Registered lamp drive decoded from the current state and active channel.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      red_q     <= '0;
      yel_q     <= '0;
      grn_q     <= '0;
      act_out_q <= '0;
    end else begin
      red_q     <= '0;
      yel_q     <= '0;
      grn_q     <= '0;
      act_out_q <= act_q;
      case (state_q)
        ST_UNMANAGED: yel_q <= {N_CH{yb_on_q}};
        ST_CLR:       red_q <= '1;
        ST_RY: begin
          red_q <= '1;
          yel_q <= act_oh;
        end
        ST_G: begin
          red_q <= ~act_oh;
          grn_q <= act_oh;
        end
        ST_GBLINK: begin
          red_q <= ~act_oh;
          grn_q <= gb_on_q ? act_oh : '0;
        end
        ST_Y: begin
          red_q <= ~act_oh;
          yel_q <= act_oh;
        end
        default: ;
      endcase
    end
  end

  assign red_o       = red_q;
  assign yellow_o    = yel_q;
  assign green_o     = grn_q;
  assign active_ch_o = act_out_q;

endmodule

// File: tb/tb_traffic_lights_xn.sv
// tb_traffic_lights_xn: directed and random stimulus for traffic_lights_xn, with a
// phase-timeline reference model. Build macro DEMAND_SKIP_EN enables the demand-skip test.
module tb_traffic_lights_xn;

  localparam int N = 4, P = 2, DG = 10, DY = 3, DC = 2, RYMS = 3, BG = 1, GT = 4, BY = 8;
  localparam int S_OFF = 0, S_UN = 1, S_CLR = 2, S_RY = 3, S_G = 4, S_GB = 5, S_Y = 6;

  logic         clk = 1'b0;
  logic         arst;
  logic         cmd_valid;
  logic [2:0]   cmd_type;
  logic [15:0]  cmd_data;
  logic [1:0]   cmd_ch;
  logic [N-1:0] req;
  logic [N-1:0] red_o, yellow_o, green_o;
  logic [1:0]   active_ch_o;

  int errors = 0;
  int checks = 0;

  // Reference model: a phase with a remaining-cycle count and an elapsed-cycle count.
  int         m_st, m_left, m_el, m_act, m_y, m_clr;
  int         m_g [N];
  bit         m_wait;
  bit [N-1:0] m_pend;

  always #5 clk = ~clk;

  traffic_lights_xn #(
    .N_CH(N), .CLK_PER_MS(P), .DEF_G_MS(DG), .DEF_Y_MS(DY), .DEF_CLR_MS(DC),
    .STATE_RY_MS(RYMS), .BLINK_G_MS(BG), .G_BLINK_T(GT), .BLINK_Y_MS(BY)
  ) dut (
    .clk_i(clk), .arst_i(arst), .cmd_valid_i(cmd_valid), .cmd_type_i(cmd_type),
    .cmd_data_i(cmd_data), .cmd_ch_i(cmd_ch), .req_i(req), .red_o(red_o),
    .yellow_o(yellow_o), .green_o(green_o), .active_ch_o(active_ch_o)
  );

  function automatic int dur(int s);
    case (s)
      S_CLR:   return m_clr;
      S_RY:    return RYMS;
      S_G:     return m_g[m_act];
      S_GB:    return 2 * GT * BG;
      S_Y:     return m_y;
      default: return 0;
    endcase
  endfunction

  task automatic m_enter(int s);
    m_st   = s;
    m_el   = 0;
    m_left = dur(s) * P;
    m_wait = 1'b0;
  endtask

  task automatic m_reset();
    m_st = S_OFF; m_left = 0; m_el = 0; m_act = 0; m_wait = 1'b0; m_pend = '0;
    m_y = DY; m_clr = DC;
    for (int i = 0; i < N; i++) m_g[i] = DG;
  endtask

  function automatic int m_pick();
    for (int k = 1; k <= N; k++) begin
      if (m_pend[(m_act + k) % N]) return (m_act + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3*N+1:0] m_lamps();
    logic [N-1:0] r, y, g, oh;
    r = '0; y = '0; g = '0;
    oh = N'(1) << m_act;
    case (m_st)
      S_UN:  if ((m_el / (BY * P)) % 2 == 0) y = '1;
      S_CLR: r = '1;
      S_RY:  begin r = '1; y = oh; end
      S_G:   begin r = ~oh; g = oh; end
      S_GB:  begin r = ~oh; if ((m_el / (BG * P)) % 2 == 0) g = oh; end
      S_Y:   begin r = ~oh; y = oh; end
      default: ;
    endcase
    return {r, y, g, 2'(m_act)};
  endfunction

  task automatic m_step(bit v, int t, int d, int ch, bit [N-1:0] r);
    bit mode, eg, expire;
    int p;
    mode = 1'b0; eg = 1'b0;
    if (v) begin
      if (t == 0 && (m_st == S_OFF || m_st == S_UN)) begin
        m_act = 0; m_enter(S_CLR); mode = 1'b1;
      end else if (t == 1) begin
        m_st = S_OFF; mode = 1'b1;
      end else if (t == 2) begin
        m_enter(S_UN); mode = 1'b1;
      end
    end
    if (!mode) begin
      if (m_st == S_UN) begin
        m_el++;
      end else if (m_st != S_OFF) begin
        expire = (m_st == S_CLR && m_wait) || m_left == 1;
        if (!expire) begin
          m_left--; m_el++;
        end else begin
          case (m_st)
            S_CLR: begin
`ifdef DEMAND_SKIP_EN
              p = m_pick();
              if (p >= 0) begin m_act = p; m_enter(S_RY); end
              else begin m_wait = 1'b1; m_left = 0; end
`else
              p = 0;
              m_enter(S_RY);
`endif
            end
            S_RY: begin m_enter(S_G); eg = 1'b1; end
            S_G:  m_enter(S_GB);
            S_GB: m_enter(S_Y);
            default: begin
`ifndef DEMAND_SKIP_EN
              m_act = (m_act + 1) % N;
`endif
              m_enter(S_CLR);
            end
          endcase
        end
      end
    end
    if (v && d != 0) begin
      if (t == 3 && ch < N) m_g[ch] = d;
      if (t == 4) m_clr = d;
      if (t == 5) m_y = d;
    end
    m_pend = (m_pend & ~(eg ? (N'(1) << m_act) : N'(0))) | r;
  endtask

  // One clock: model advances on the edge, DUT lamps are compared on the falling edge.
  task automatic cyc();
    logic [3*N+1:0] exp, got;
    bit was_un;
    @(posedge clk);
    exp    = m_lamps();
    was_un = (m_st == S_UN);
    if (arst) m_reset();
    else m_step(cmd_valid, int'(cmd_type), int'(cmd_data), int'(cmd_ch), req);
    @(negedge clk);
    got = {red_o, yellow_o, green_o, active_ch_o};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL lamps t=%0t observed=%h expected=%h", $time, got, exp);
    end
    if (!was_un) begin
      checks++;
      assert ($countones(green_o | yellow_o) <= 1) else begin
        errors++;
        $error("FAIL mutex t=%0t observed g=%b y=%b expected at most one bit", $time, green_o, yellow_o);
      end
    end
  endtask

  task automatic cmd(int t, int d, int ch);
    cmd_valid = 1'b1; cmd_type = 3'(t); cmd_data = 16'(d); cmd_ch = 2'(ch);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_st(int st, int ch, int budget, string tag);
    int n;
    n = 0;
    while (!(m_st == st && (ch < 0 || m_act == ch)) && n < budget) begin cyc(); n++; end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL %s timeout observed=%0d cycles expected<%0d", tag, n, budget);
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int g0, y0, n, r;
    arst = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_data = '0; cmd_ch = '0; req = '0;
    m_reset();
    #2;
    chk("reset_lamps", int'({red_o, yellow_o, green_o, active_ch_o}), 0);
    run(2);
    #3 arst = 1'b0;
    run(4);

    // Test 1: default timing over two full rotations.
    cmd(0, 0, 0);
    g0 = 0; y0 = 0;
    for (int i = 0; i < 52; i++) begin
      cyc();
      g0 += int'(green_o[0]);
      y0 += int'(yellow_o[0]);
    end
    cyc();
    chk("t1_active_after_rot", int'(active_ch_o), 1);
    chk("t1_clr_red", int'(red_o), 15);
    chk("t1_ch0_green_cycles", g0, 28);
    chk("t1_ch0_yellow_cycles", y0, 12);
    run(2 * 208 - 53);

    // Test 2: register writes apply from the next phase load; data=0 writes are ignored.
    cmd(3, 5, 2);
    cmd(5, 1, 0);
    cmd(4, 7, 0);
    cmd(3, 0, 1);
    cmd(4, 0, 0);
    wait_st(S_G, 2, 400, "t2_wait_g2");
    n = 0;
    cyc();
    while (green_o[2] && n < 100) begin n++; cyc(); end
    chk("t2_ch2_green_run", n, 12);
    run(300);

    // Test 3: unmanaged entered mid-green, then restart.
    wait_st(S_G, -1, 400, "t3_wait_g");
    run(5);
    cmd(2, 0, 0);
    cyc();
    chk("t3_unm_yellow", int'(yellow_o), 15);
    chk("t3_unm_red", int'(red_o | green_o), 0);
    run(40);
    cmd(0, 0, 0);
    run(60);

    // Test 4: asynchronous reset during green blink.
    wait_st(S_GB, -1, 400, "t4_wait_gb");
    run(3);
    #2 arst = 1'b1;
    #1;
    chk("t4_async_clear", int'({red_o, yellow_o, green_o, active_ch_o}), 0);
    m_reset();
    run(3);
    #3 arst = 1'b0;
    run(4);
    cmd(0, 0, 0);
    run(210);

    // Test 5: off coincident with yellow expiry.
    n = 0;
    while (!(m_st == S_Y && m_left == 1) && n < 400) begin cyc(); n++; end
    chk("t5_reach_y_end", int'(n < 400), 1);
    cmd(1, 0, 0);
    cyc();
    chk("t5_off_lamps", int'({red_o, yellow_o, green_o}), 0);
    run(30);

    // Randomized commands and requests.
    cmd(0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      req = ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 15)) : '0;
      if ($urandom_range(0, 99) < 4) begin
        r = $urandom_range(0, 19);
        if (r < 3) cmd(0, 0, 0);
        else if (r == 3) cmd(1, 0, 0);
        else if (r == 4) cmd(2, 0, 0);
        else if (r < 16) cmd(3 + (r % 3), $urandom_range(0, 6), $urandom_range(0, 3));
        else cmd(6 + (r % 2), $urandom_range(0, 6), 0);
      end else begin
        cyc();
      end
    end
    req = '0;

`ifdef DEMAND_SKIP_EN
    // Test 6: demand skip; ch0 served, then ch3 directly, then all-red hold.
    cmd(1, 0, 0);
    cmd(4, 2, 0);
    cmd(5, 3, 0);
    cmd(3, 10, 0);
    cmd(0, 0, 0);
    run(30);
    chk("t6_hold_red", int'(red_o), 15);
    req = 4'b0001; cyc(); req = '0;
    wait_st(S_G, 0, 200, "t6_wait_g0");
    req = 4'b1000; cyc(); req = '0;
    wait_st(S_RY, -1, 200, "t6_wait_ry");
    run(2);
    chk("t6_skip_to_ch3", int'(active_ch_o), 3);
    run(300);
    chk("t6_idle_red", int'(red_o), 15);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
